// File: rtl/rv_decode_hz.sv
// rv_decode_hz: RISC-V instruction-decode stage between IF/ID and ID/EX.
// Holds the integer register file and decodes the opcode class and immediate.
// Detects load-use hazards and inserts one bubble per hazard.
// ID/EX advances under a valid/ready handshake, with flush and a bubble counter.
module rv_decode_hz #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_ir,
  input  logic [XLEN-1:0]  if_id_pc,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             mem_wb_we,
  input  logic [31:0]      mem_wb_ir,
  input  logic [XLEN-1:0]  mem_wb_out,
  output logic             id_stall,
  output logic             id_ex_valid,
  output logic [31:0]      id_ex_ir,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_rs1,
  output logic [XLEN-1:0]  id_ex_rs2,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic             id_ex_illegal,
  output logic [CNT_W-1:0] hz_cnt
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_U,
    CLS_J,
    CLS_R,
    CLS_X
  } cls_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } id_ex_t;

  // Register-file and pipeline state
  logic [XLEN-1:0]  rf_q [NREG];
  logic [XLEN-1:0]  rf_d [NREG];
  id_ex_t           id_ex_q;
  id_ex_t           id_ex_d;
  logic [CNT_W-1:0] hz_cnt_q;
  logic [CNT_W-1:0] hz_cnt_d;

  // Decode fields of the instruction in ID
  cls_e                cls;
  logic                use_rs1;
  logic                use_rs2;
  logic [4:0]          rs1_idx;
  logic [4:0]          rs2_idx;
  logic signed [31:0]  imm32;
  logic [XLEN-1:0]     imm_x;
  logic [XLEN-1:0]     rs1_val;
  logic [XLEN-1:0]     rs2_val;

  // Writeback and hazard terms
  logic [4:0] wb_rd;
  logic       wb_en;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       hazard;
  logic       hold;

  // Only the rd field of the writeback instruction is needed here.
  logic unused_wb_ir_bits;
  assign unused_wb_ir_bits = ^{mem_wb_ir[31:12], mem_wb_ir[6:0]};

  assign rs1_idx = if_id_ir[19:15];
  assign rs2_idx = if_id_ir[24:20];
  assign wb_rd   = mem_wb_ir[11:7];

  // Writes to x0 or to an index beyond the implemented file are discarded.
  assign wb_en = mem_wb_we && (wb_rd != 5'd0) && (int'(wb_rd) < NREG);

  // Map the major opcode onto an immediate-format class
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    cls = CLS_X;
    case (if_id_ir[6:0])
      OP_LOAD, OP_IMM, OP_JALR: cls = CLS_I;
      OP_STORE:                 cls = CLS_S;
      OP_BRANCH:                cls = CLS_B;
      OP_LUI, OP_AUIPC:         cls = CLS_U;
      OP_JAL:                   cls = CLS_J;
      OP_REG:                   cls = CLS_R;
      default:                  cls = CLS_X;
    endcase
  end

  assign use_rs1 = (cls == CLS_I) || (cls == CLS_S) || (cls == CLS_B) || (cls == CLS_R);
  assign use_rs2 = (cls == CLS_S) || (cls == CLS_B) || (cls == CLS_R);

  // Assemble the 32-bit immediate for the decoded class, sign-extended from ir[31]
  always_comb begin
    imm32 = '0;
    case (cls)
      CLS_I: imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
      CLS_S: imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
      CLS_B: imm32 = {{19{if_id_ir[31]}}, if_id_ir[31], if_id_ir[7],
                      if_id_ir[30:25], if_id_ir[11:8], 1'b0};
      CLS_U: imm32 = {if_id_ir[31:12], 12'b0};
      CLS_J: imm32 = {{11{if_id_ir[31]}}, if_id_ir[31], if_id_ir[19:12],
                      if_id_ir[20], if_id_ir[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32 is signed, so widening to XLEN carries the sign bit upward.
  assign imm_x = XLEN'(imm32);

  // Read both source operands, honouring x0, the register limit and the optional WB bypass
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && (rs1_idx != 5'd0) && (int'(rs1_idx) < NREG)) begin
      if ((BYPASS != 0) && wb_en && (wb_rd == rs1_idx)) begin
        rs1_val = mem_wb_out;
      end else begin
        rs1_val = rf_q[rs1_idx[RIDX_W-1:0]];
      end
    end
    if (use_rs2 && (rs2_idx != 5'd0) && (int'(rs2_idx) < NREG)) begin
      if ((BYPASS != 0) && wb_en && (wb_rd == rs2_idx)) begin
        rs2_val = mem_wb_out;
      end else begin
        rs2_val = rf_q[rs2_idx[RIDX_W-1:0]];
      end
    end
  end

  // Next register-file contents: at most one writeback per cycle
  always_comb begin
    rf_d = rf_q;
    if (wb_en) begin
      rf_d[wb_rd[RIDX_W-1:0]] = mem_wb_out;
    end
  end

  // A load in EX whose rd feeds a source actually used by the instruction in ID
  assign ex_rd      = id_ex_q.ir[11:7];
  assign ex_is_load = (id_ex_q.ir[6:0] == OP_LOAD);
  assign hazard     = if_id_valid && id_ex_q.valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((use_rs1 && (rs1_idx == ex_rd)) || (use_rs2 && (rs2_idx == ex_rd)));
  assign hold       = id_ex_q.valid && !ex_ready;

  // Flush kills the ID instruction outright, so it never asks IF/ID to hold.
  assign id_stall = !rst && !flush && (hazard || hold);

  // ID/EX next state: flush, then hold, then bubble, then normal capture
  always_comb begin
    id_ex_d  = id_ex_q;
    hz_cnt_d = hz_cnt_q;
    if (flush) begin
      id_ex_d = '0;
    end else if (hold) begin
      id_ex_d = id_ex_q;
    end else if (hazard) begin
      id_ex_d = '0;
      if (hz_cnt_q != '1) begin
        hz_cnt_d = hz_cnt_q + CNT_W'(1);
      end
    end else begin
      id_ex_d.valid   = if_id_valid;
      id_ex_d.ir      = if_id_ir;
      id_ex_d.pc      = if_id_pc;
      id_ex_d.rs1     = rs1_val;
      id_ex_d.rs2     = rs2_val;
      id_ex_d.imm     = imm_x;
      id_ex_d.illegal = (cls == CLS_X);
    end
  end

  // Clocked state with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      id_ex_q  <= '0;
      hz_cnt_q <= '0;
      // NOTE: the register file is architecturally zero after reset, so this memory is cleared explicitly.
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      id_ex_q  <= id_ex_d;
      hz_cnt_q <= hz_cnt_d;
      rf_q     <= rf_d;
    end
  end

  assign id_ex_valid   = id_ex_q.valid;
  assign id_ex_ir      = id_ex_q.ir;
  assign id_ex_pc      = id_ex_q.pc;
  assign id_ex_rs1     = id_ex_q.rs1;
  assign id_ex_rs2     = id_ex_q.rs2;
  assign id_ex_imm     = id_ex_q.imm;
  assign id_ex_illegal = id_ex_q.illegal;
  assign hz_cnt        = hz_cnt_q;

endmodule

// File: tb/tb_rv_decode_hz.sv
// tb_rv_decode_hz: drives two decode stages from shared inputs and compares them with a reference model.
// Instance 0 is RV32I with bypass and a 16-bit counter.
// Instance 1 is RV32E without bypass and a 2-bit counter.
module tb_rv_decode_hz;

  localparam int C_I = 0, C_S = 1, C_B = 2, C_U = 3, C_J = 4, C_R = 5, C_X = 6;

  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw   x5, 0(x1)
  localparam logic [31:0] ADD_DEP = 32'h00128333; // add  x6, x5, x1
  localparam logic [31:0] ADD_IND = 32'h00208333; // add  x6, x1, x2
  localparam logic [31:0] LW_X4   = 32'h00022383; // lw   x7, 0(x4)
  localparam logic [31:0] ADDI_X0 = 32'h00000393; // addi x7, x0, 0
  localparam logic [31:0] ADDI_X20= 32'h000A0393; // addi x7, x20, 0

  logic        clk = 1'b0;
  logic        rst, if_id_valid, ex_ready, flush, mem_wb_we;
  logic [31:0] if_id_ir, if_id_pc, mem_wb_ir, mem_wb_out;
  logic [31:0] pc_ctr = 32'h0000_1000;

  wire [1:0]       o_stall, o_valid, o_ill;
  wire [1:0][31:0] o_ir, o_pc, o_rs1, o_rs2, o_imm;
  wire [15:0]      hz0;
  wire [1:0]       hz1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_decode_hz #(.XLEN(32), .NREG(32), .BYPASS(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
    .ex_ready(ex_ready), .flush(flush), .mem_wb_we(mem_wb_we), .mem_wb_ir(mem_wb_ir),
    .mem_wb_out(mem_wb_out), .id_stall(o_stall[0]), .id_ex_valid(o_valid[0]), .id_ex_ir(o_ir[0]),
    .id_ex_pc(o_pc[0]), .id_ex_rs1(o_rs1[0]), .id_ex_rs2(o_rs2[0]), .id_ex_imm(o_imm[0]),
    .id_ex_illegal(o_ill[0]), .hz_cnt(hz0)
  );

  rv_decode_hz #(.XLEN(32), .NREG(16), .BYPASS(0), .CNT_W(2)) dut_e (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
    .ex_ready(ex_ready), .flush(flush), .mem_wb_we(mem_wb_we), .mem_wb_ir(mem_wb_ir),
    .mem_wb_out(mem_wb_out), .id_stall(o_stall[1]), .id_ex_valid(o_valid[1]), .id_ex_ir(o_ir[1]),
    .id_ex_pc(o_pc[1]), .id_ex_rs1(o_rs1[1]), .id_ex_rs2(o_rs2[1]), .id_ex_imm(o_imm[1]),
    .id_ex_illegal(o_ill[1]), .hz_cnt(hz1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        valid;
    logic [31:0] ir, pc, rs1, rs2, imm;
    logic        ill;
    int          cnt;
  } ex_t;

  ex_t         m [2];
  logic [31:0] rf [2][32];

  function automatic int nreg_of(input int k); return (k == 0) ? 32 : 16; endfunction
  function automatic bit byp_of(input int k); return (k == 0); endfunction
  function automatic int cmax_of(input int k); return (k == 0) ? 65535 : 3; endfunction
  function automatic int hz_of(input int k); return (k == 0) ? int'(hz0) : int'(hz1); endfunction

  function automatic int cls_of(input logic [31:0] ir);
    case (ir[6:0])
      7'h03, 7'h13, 7'h67: return C_I;
      7'h23:               return C_S;
      7'h63:               return C_B;
      7'h37, 7'h17:        return C_U;
      7'h6F:               return C_J;
      7'h33:               return C_R;
      default:             return C_X;
    endcase
  endfunction

  function automatic bit uses1(input int c); return c == C_I || c == C_S || c == C_B || c == C_R; endfunction
  function automatic bit uses2(input int c); return c == C_S || c == C_B || c == C_R; endfunction

  // Immediates via arithmetic shifts and field placement
  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    logic signed [31:0] s;
    s = ir;
    case (cls_of(ir))
      C_I: return 32'(s >>> 20);
      C_S: return 32'((s >>> 25) <<< 5) | 32'(ir[11:7]);
      C_B: return 32'((s >>> 31) <<< 12) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
      C_U: return ir & 32'hFFFF_F000;
      C_J: return 32'((s >>> 31) <<< 20) | (32'(ir[19:12]) << 12) | (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= nreg_of(k)) return 32'h0;
    if (byp_of(k) && mem_wb_we && mem_wb_ir[11:7] == idx) return mem_wb_out;
    return rf[k][idx];
  endfunction

  function automatic bit m_hazard(input int k);
    int         c;
    logic [4:0] rd;
    c  = cls_of(if_id_ir);
    rd = m[k].ir[11:7];
    if (!if_id_valid || !m[k].valid || m[k].ir[6:0] != 7'h03 || rd == 0) return 1'b0;
    return (uses1(c) && if_id_ir[19:15] == rd) || (uses2(c) && if_id_ir[24:20] == rd);
  endfunction

  function automatic bit m_stall(input int k);
    return !rst && !flush && (m_hazard(k) || (m[k].valid && !ex_ready));
  endfunction

  // Advance the model on the current inputs, then let the DUTs take the same edge
  task automatic tick();
    ex_t nx;
    int  c;
    for (int k = 0; k < 2; k++) begin
      nx = m[k];
      if (rst) begin
        nx = '{default: 0};
        for (int r = 0; r < 32; r++) rf[k][r] = 32'h0;
      end else begin
        c = cls_of(if_id_ir);
        if (flush || (!(m[k].valid && !ex_ready) && m_hazard(k))) begin
          nx.valid = 0; nx.ir = 0; nx.pc = 0; nx.rs1 = 0; nx.rs2 = 0; nx.imm = 0; nx.ill = 0;
          if (!flush && nx.cnt < cmax_of(k)) nx.cnt++;
        end else if (!(m[k].valid && !ex_ready)) begin
          nx.valid = if_id_valid;
          nx.ir    = if_id_ir;
          nx.pc    = if_id_pc;
          nx.rs1   = uses1(c) ? m_read(k, if_id_ir[19:15]) : 32'h0;
          nx.rs2   = uses2(c) ? m_read(k, if_id_ir[24:20]) : 32'h0;
          nx.imm   = imm_of(if_id_ir);
          nx.ill   = (c == C_X);
        end
        if (mem_wb_we && mem_wb_ir[11:7] != 0 && int'(mem_wb_ir[11:7]) < nreg_of(k))
          rf[k][mem_wb_ir[11:7]] = mem_wb_out;
      end
      m[k] = nx;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle(); #1; endtask

  task automatic set_in(input logic v, input logic [31:0] ir, input logic rdy, input logic fl);
    if_id_valid = v; if_id_ir = ir; if_id_pc = pc_ctr; pc_ctr += 4;
    ex_ready = rdy; flush = fl; mem_wb_we = 1'b0; mem_wb_ir = 32'h0; mem_wb_out = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_in(1'b0, 32'h0, 1'b1, 1'b0); tick(); rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, LW_X5, 1'b0, 1'b0);
    mem_wb_we = 1'b1; mem_wb_ir = 32'h0000_0233; mem_wb_out = 32'h5555_AAAA;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_stall[k] !== 1'b0) begin n_err++; $display("FAIL reset_stall[%0d]: got %b want 0", k, o_stall[k]); end
      n_vec++; if (o_valid[k] !== 1'b0 || o_ill[k] !== 1'b0) begin n_err++; $display("FAIL reset_flags[%0d]: got v=%b ill=%b want 0", k, o_valid[k], o_ill[k]); end
      n_vec++; if ({o_ir[k], o_pc[k], o_rs1[k], o_rs2[k], o_imm[k]} !== 160'h0) begin n_err++; $display("FAIL reset_data[%0d]: got ir=%h pc=%h rs1=%h rs2=%h imm=%h want 0", k, o_ir[k], o_pc[k], o_rs1[k], o_rs2[k], o_imm[k]); end
      n_vec++; if (hz_of(k) !== 0) begin n_err++; $display("FAIL reset_hz[%0d]: got %0d want 0", k, hz_of(k)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_immediates();
    logic [31:0] irs  [5] = '{32'hFFF00003, 32'h80000037, 32'hFE000FE3, ADD_IND, 32'h0000004C};
    logic [31:0] imms [5] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h0};
    logic        ills [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, irs[i], 1'b1, 1'b0);
      tick();
      n_vec++; if (o_imm[0] !== imms[i]) begin n_err++; $display("FAIL imm ir=%h: got %h want %h", irs[i], o_imm[0], imms[i]); end
      n_vec++; if (o_ill[0] !== ills[i]) begin n_err++; $display("FAIL illegal ir=%h: got %b want %b", irs[i], o_ill[0], ills[i]); end
    end
  endtask

  task automatic test_regfile();
    logic [31:0] want0, want1;
    do_reset();
    // Same-cycle WB x4 with a load reading x4: bypass only on instance 0
    set_in(1'b1, LW_X4, 1'b1, 1'b0);
    mem_wb_we = 1'b1; mem_wb_ir = 32'h0000_0233; mem_wb_out = 32'hDEADBEEF;
    tick();
    n_vec++; if (o_rs1[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rf_bypass: got %h want deadbeef", o_rs1[0]); end
    n_vec++; if (o_rs1[1] !== 32'h0) begin n_err++; $display("FAIL rf_nobypass: got %h want 0", o_rs1[1]); end
    // WB to x0 alongside an x0 read
    set_in(1'b1, ADDI_X0, 1'b1, 1'b0);
    mem_wb_we = 1'b1; mem_wb_ir = 32'h0000_0033; mem_wb_out = 32'h12345678;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_rs1[k] !== 32'h0) begin n_err++; $display("FAIL rf_x0_same[%0d]: got %h want 0", k, o_rs1[k]); end
    end
    // Registered read of x4 while writing x20 (dropped on the 16-register instance)
    set_in(1'b1, LW_X4, 1'b1, 1'b0);
    mem_wb_we = 1'b1; mem_wb_ir = 32'h0000_0A33; mem_wb_out = 32'hCAFEF00D;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_rs1[k] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rf_x4_stored[%0d]: got %h want deadbeef", k, o_rs1[k]); end
    end
    set_in(1'b1, ADDI_X0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_rs1[k] !== 32'h0) begin n_err++; $display("FAIL rf_x0_later[%0d]: got %h want 0", k, o_rs1[k]); end
    end
    set_in(1'b1, ADDI_X20, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      want0 = (k == 0) ? 32'hCAFEF00D : 32'h0;
      n_vec++; if (o_rs1[k] !== want0) begin n_err++; $display("FAIL rf_x20[%0d]: got %h want %h", k, o_rs1[k], want0); end
    end
    // x4 on the 16-register file is untouched by the x20 write
    set_in(1'b1, LW_X4, 1'b1, 1'b0);
    tick();
    want1 = 32'hDEADBEEF;
    n_vec++; if (o_rs1[1] !== want1) begin n_err++; $display("FAIL rf_x20_alias: got %h want %h", o_rs1[1], want1); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1'b1, LW_X5, 1'b1, 1'b0);
    tick();
    set_in(1'b1, ADD_DEP, 1'b1, 1'b0);
    settle();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_stall[k] !== 1'b1) begin n_err++; $display("FAIL lu_stall[%0d]: got %b want 1", k, o_stall[k]); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_valid[k] !== 1'b0 || hz_of(k) !== 1) begin n_err++; $display("FAIL lu_bubble[%0d]: got v=%b hz=%0d want v=0 hz=1", k, o_valid[k], hz_of(k)); end
    end
    settle();
    n_vec++; if (o_stall[0] !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", o_stall[0]); end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_valid[k] !== 1'b1 || o_ir[k] !== ADD_DEP || hz_of(k) !== 1) begin n_err++; $display("FAIL lu_issue[%0d]: got v=%b ir=%h hz=%0d want v=1 ir=%h hz=1", k, o_valid[k], o_ir[k], hz_of(k), ADD_DEP); end
    end
    set_in(1'b1, LW_X5, 1'b1, 1'b0);
    tick();
    set_in(1'b1, ADD_IND, 1'b1, 1'b0);
    settle();
    n_vec++; if (o_stall[0] !== 1'b0) begin n_err++; $display("FAIL lu_indep_stall: got %b want 0", o_stall[0]); end
    tick();
    n_vec++; if (o_valid[0] !== 1'b1 || o_ir[0] !== ADD_IND || hz0 !== 16'd1) begin n_err++; $display("FAIL lu_indep_issue: got v=%b ir=%h hz=%0d want v=1 ir=%h hz=1", o_valid[0], o_ir[0], hz0, ADD_IND); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_pc;
    do_reset();
    set_in(1'b1, ADD_IND, 1'b1, 1'b0);
    held_pc = if_id_pc;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, ADDI_X0, 1'b0, 1'b0);
      settle();
      n_vec++; if (o_stall[0] !== 1'b1) begin n_err++; $display("FAIL bp_stall cycle %0d: got %b want 1", i, o_stall[0]); end
      tick();
      n_vec++; if (o_valid[0] !== 1'b1 || o_ir[0] !== ADD_IND || o_pc[0] !== held_pc) begin n_err++; $display("FAIL bp_hold cycle %0d: got v=%b ir=%h pc=%h want v=1 ir=%h pc=%h", i, o_valid[0], o_ir[0], o_pc[0], ADD_IND, held_pc); end
    end
    set_in(1'b1, ADDI_X0, 1'b1, 1'b0);
    settle();
    n_vec++; if (o_stall[0] !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", o_stall[0]); end
    tick();
    n_vec++; if (o_valid[0] !== 1'b1 || o_ir[0] !== ADDI_X0) begin n_err++; $display("FAIL bp_next: got v=%b ir=%h want v=1 ir=%h", o_valid[0], o_ir[0], ADDI_X0); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, LW_X5, 1'b1, 1'b0);
    tick();
    set_in(1'b1, ADD_DEP, 1'b0, 1'b1);
    settle();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_stall[k] !== 1'b0) begin n_err++; $display("FAIL flush_stall[%0d]: got %b want 0", k, o_stall[k]); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_valid[k] !== 1'b0 || o_ir[k] !== 32'h0 || hz_of(k) !== 0) begin n_err++; $display("FAIL flush_result[%0d]: got v=%b ir=%h hz=%0d want 0 0 0", k, o_valid[k], o_ir[k], hz_of(k)); end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_in(1'b1, LW_X5, 1'b1, 1'b0);   tick();
    set_in(1'b1, ADD_DEP, 1'b1, 1'b0); tick(); tick();
    set_in(1'b1, LW_X5, 1'b1, 1'b0);   tick();
    set_in(1'b1, ADD_DEP, 1'b1, 1'b0);
    settle();
    n_vec++; if (o_stall[0] !== 1'b1 || hz0 !== 16'd1) begin n_err++; $display("FAIL rst_mid_pre: got stall=%b hz=%0d want 1 1", o_stall[0], hz0); end
    rst = 1'b1;
    settle();
    n_vec++; if (o_stall[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %b want 0", o_stall[0]); end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (o_valid[k] !== 1'b0 || o_ir[k] !== 32'h0 || o_rs1[k] !== 32'h0 || hz_of(k) !== 0) begin n_err++; $display("FAIL rst_mid_state[%0d]: got v=%b ir=%h rs1=%h hz=%0d want all 0", k, o_valid[k], o_ir[k], o_rs1[k], hz_of(k)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, LW_X5, 1'b1, 1'b0);   tick();
      set_in(1'b1, ADD_DEP, 1'b1, 1'b0); tick(); tick();
    end
    n_vec++; if (hz0 !== 16'd5) begin n_err++; $display("FAIL sat_hz_wide: got %0d want 5", hz0); end
    n_vec++; if (hz1 !== 2'd3) begin n_err++; $display("FAIL sat_hz_narrow: got %0d want 3", hz1); end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 12))
      0, 10, 11, 12: w[6:0] = 7'h03;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h67;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h33;
      default: w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) != 0, rand_ir(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      mem_wb_we  = $urandom_range(0, 1);
      mem_wb_ir  = $urandom;
      if ($urandom_range(0, 1) == 1) mem_wb_ir[11:7] = 5'($urandom_range(0, 7));
      mem_wb_out = $urandom;
      settle();
      for (int k = 0; k < 2; k++) begin
        n_vec++; if (o_stall[k] !== m_stall(k)) begin n_err++; $display("FAIL rnd_stall[%0d] n=%0d: got %b want %b", k, n, o_stall[k], m_stall(k)); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++; if (o_valid[k] !== m[k].valid || o_ir[k] !== m[k].ir || o_ill[k] !== m[k].ill) begin n_err++; $display("FAIL rnd_ctl[%0d] n=%0d: got v=%b ir=%h ill=%b want v=%b ir=%h ill=%b", k, n, o_valid[k], o_ir[k], o_ill[k], m[k].valid, m[k].ir, m[k].ill); end
        n_vec++; if (o_rs1[k] !== m[k].rs1 || o_rs2[k] !== m[k].rs2 || o_imm[k] !== m[k].imm) begin n_err++; $display("FAIL rnd_data[%0d] n=%0d: got rs1=%h rs2=%h imm=%h want rs1=%h rs2=%h imm=%h", k, n, o_rs1[k], o_rs2[k], o_imm[k], m[k].rs1, m[k].rs2, m[k].imm); end
        if (m[k].valid) begin
          n_vec++; if (o_pc[k] !== m[k].pc) begin n_err++; $display("FAIL rnd_pc[%0d] n=%0d: got %h want %h", k, n, o_pc[k], m[k].pc); end
        end
        n_vec++; if (hz_of(k) !== m[k].cnt) begin n_err++; $display("FAIL rnd_hz[%0d] n=%0d: got %0d want %0d", k, n, hz_of(k), m[k].cnt); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      m[k] = '{default: 0};
      for (int r = 0; r < 32; r++) rf[k][r] = 32'h0;
    end
    test_reset();
    test_immediates();
    test_regfile();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_decode_hz.md
Name: rv_decode_hz

Overview:
Parametrised RISC-V instruction-decode stage that succeeds rv_decode. It sits between the IF/ID and ID/EX pipeline registers, holds the integer register file, and registers the decoded operands and the full-width sign-extended immediate into ID/EX. Compared with rv_decode it adds a valid/ready handshake, load-use hazard detection with bubble insertion, flush, write-through regfile bypass, an illegal-opcode flag and a bubble counter.

Parameters:
XLEN, 32, datapath width of pc, register and immediate outputs (32 or 64)
NREG, 32, number of architectural registers (32 = RV32I, 16 = RV32E); rd/rs >= NREG reads 0 and writes are dropped
BYPASS, 1, 1 = same-cycle WB write is visible to the ID read; 0 = registered read-after-write only
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_ir  in  32  fetched instruction
if_id_pc  in  XLEN  pc of if_id_ir
ex_ready  in  1  EX can accept the ID/EX contents this cycle
flush  in  1  kill the instruction in ID (branch/jump redirect)
mem_wb_we  in  1  writeback enable
mem_wb_ir  in  32  writeback instruction; rd = mem_wb_ir[11:7]
mem_wb_out  in  XLEN  writeback data
id_stall  out  1  IF/ID must hold (combinational)
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_ir  out  32  registered instruction
id_ex_pc  out  XLEN  registered pc
id_ex_rs1  out  XLEN  rs1 operand
id_ex_rs2  out  XLEN  rs2 operand
id_ex_imm  out  XLEN  sign-extended immediate
id_ex_illegal  out  1  unsupported opcode
hz_cnt  out  CNT_W  count of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst=1 at an edge): all id_ex_* = 0, hz_cnt = 0, all registers = 0, WB write ignored. id_stall = 0 while rst is high.
- Latency: 1 cycle from IF/ID to ID/EX.
- Opcode classes:
  - I: 0000011 LOAD, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - Anything else, including ir[1:0] != 11, is illegal: imm = 0 and illegal = 1.
- Immediate values, each sign-extended from ir[31] to XLEN:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - R: 0.
- Register file:
  - x0 always reads 0.
  - Write on edge when mem_wb_we=1, rd != 0 and rd < NREG.
  - With BYPASS=1, a read whose index equals a same-cycle valid write returns mem_wb_out.
  - With BYPASS=0, the read returns the old value.
- Operand usage: rs1 is used by all classes except U and J; rs2 is used by R, S and B. Unused operand outputs are 0.
- Hazard condition, computed combinationally: hazard = if_id_valid & id_ex_valid & (id_ex_ir[6:0] == LOAD) & (id_ex rd != 0) & (rd matches a used rs1 or rs2 of if_id_ir).
- hold = id_ex_valid & ~ex_ready.
- id_stall = ~flush & (hazard | hold).
- ID/EX update on each edge, first matching rule wins:
  1. flush: id_ex_valid = 0, id_ex_ir = 0, imm/rs1/rs2/illegal = 0.
  2. hold: all id_ex_* keep their values.
  3. hazard: bubble (same values as flush) and hz_cnt increments, saturating at all-ones.
  4. otherwise: capture the decode; id_ex_valid = if_id_valid.
- Bubble length: the bubble clears id_ex_valid, so hazard deasserts and the stalled instruction issues the next cycle. A load-use pair therefore gets exactly one bubble.
- Simultaneous events:
  - flush with hazard or hold: flush wins, no count, id_stall = 0.
  - WB write to rd with a same-cycle read of rd: governed by BYPASS.
- Reset mid-stall: reset clears state; no bubble is counted on the reset edge.

Test Plan:
- Immediates: I ir=0xFFF00003 -> imm=0xFFFFFFFF, illegal=0. U ir=0x80000037 -> imm=0x80000000. B with all imm bits set -> 0xFFFFFFFE. R -> 0. Opcode 1001100 -> imm=0, illegal=1.
- Regfile with BYPASS=1: WB rd=4, data=0xDEADBEEF in the same cycle as a LOAD with rs1=4 -> rs1=0xDEADBEEF. WB rd=0 -> a later rs1=x0 read returns 0. With NREG=16, WB rd=20 is dropped.
- Load-use: LOAD x5 followed by ADD x6,x5,x1 -> id_stall=1 for one cycle, one bubble (id_ex_valid=0), ADD issues next cycle, hz_cnt=1. ADD x6,x1,x2 after the same load -> no stall.
- Backpressure: ex_ready=0 for 3 cycles with id_ex_valid=1 -> id_ex_* stable and id_stall=1 for 3 cycles. On ex_ready=1 the next instruction is captured.
- Flush priority: flush coinciding with a hazard and with ex_ready=0 -> id_ex_valid=0, id_stall=0, hz_cnt unchanged.
- Reset mid-hazard and saturation: rst during an active stall -> all outputs 0 next cycle. With CNT_W=2 and 5 bubbles -> hz_cnt=3.
